alu_sequencer: RTL and testbench

- Sequential front-end that drives the combinational ALU (BreadBoard) from a command stream and holds a 16-bit accumulator.
- Accepts one command per valid/ready handshake, runs each arithmetic operation as `ACC op CMD_DATA`, waits a fixed settle time, then returns the 32-bit result and error flags on a valid/ready response channel.
- Sits between the host/test driver and the BreadBoard instance in the top level.

---
 rtl/alu_sequencer_pkg.sv | 30 +++
 rtl/alu_sequencer_if.sv | 25 ++
 rtl/alu_sequencer.sv | 105 ++++++++++
 tb/tb_alu_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, FSM state encoding and error-bit indices shared by the sequencer and its bench.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_CLR  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b0101;
    localparam logic [3:0] OP_MOD  = 4'b0110;
    localparam logic [3:0] OP_LOAD = 4'b0111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int ERR_RANGE = 0;
    localparam int ERR_DIV   = 1;

    // Opcodes that are sent to the external ALU rather than handled locally.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

    // Only these ops can overflow the 16-bit accumulator.
    function automatic logic is_range_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command/response valid-ready channels between the host and the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (host -> sequencer)
//   rsp_valid/rsp_ready/rsp_data/rsp_err: response channel (sequencer -> host)
interface alu_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives a combinational ALU from a command stream and holds a 16-bit accumulator.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   bus (slave)           : command / response handshake channels
//   o_acc                 : accumulator
//   o_alu_in1/in2/op      : registered operands and opcode to the ALU
//   i_alu_out, i_alu_err  : ALU result and error flags
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sequencer_if.slave        bus,
    output logic [15:0]           o_acc,
    output logic [15:0]           o_alu_in1,
    output logic [15:0]           o_alu_in2,
    output logic [3:0]            o_alu_op,
    input  logic [31:0]           i_alu_out,
    input  logic [1:0]            i_alu_err
);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_acc;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_err;
    logic [15:0] r_alu_in1;
    logic [15:0] r_alu_in2;
    logic [3:0]  r_alu_op;

    logic [15:0] w_loc_acc;
    logic [31:0] w_loc_data;
    logic [1:0]  w_loc_err;
    logic        w_div_err;
    logic        w_unused;

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_RESP);
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign o_acc         = r_acc;
    assign o_alu_in1     = r_alu_in1;
    assign o_alu_in2     = r_alu_in2;
    assign o_alu_op      = r_alu_op;

    // The ALU's own range flag is not trusted; range is derived from the upper result half.
    assign w_unused  = i_alu_err[ERR_RANGE];
    assign w_div_err = i_alu_err[ERR_DIV];

    // Results of the locally handled ops (NOP, CLR, LOAD, invalid 1xxx).
    always_comb begin
        w_loc_acc  = (bus.cmd_op == OP_CLR)  ? 16'd0 :
                     (bus.cmd_op == OP_LOAD) ? bus.cmd_data : r_acc;
        w_loc_data = (bus.cmd_op == OP_NOP)  ? {16'd0, r_acc} :
                     (bus.cmd_op == OP_LOAD) ? {16'd0, bus.cmd_data} : 32'd0;
        w_loc_err  = bus.cmd_op[3] ? 2'b11 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_acc      <= 16'd0;
            r_rsp_data <= 32'd0;
            r_rsp_err  <= 2'b00;
            r_alu_in1  <= 16'd0;
            r_alu_in2  <= 16'd0;
            r_alu_op   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && is_alu_op(bus.cmd_op)) begin
                        r_alu_in1 <= r_acc;
                        r_alu_in2 <= bus.cmd_data;
                        r_alu_op  <= bus.cmd_op;
                        r_cnt     <= 8'(SETTLE - 1);
                        r_state   <= ST_WAIT;
                    end else if (bus.cmd_valid) begin
                        r_acc      <= w_loc_acc;
                        r_rsp_data <= w_loc_data;
                        r_rsp_err  <= w_loc_err;
                        r_state    <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        // A divide error suppresses the result and leaves ACC untouched.
                        r_rsp_data <= w_div_err ? 32'd0 : i_alu_out;
                        r_rsp_err  <= {w_div_err, is_range_op(r_alu_op) & (|i_alu_out[31:16])};
                        r_acc      <= w_div_err ? r_acc : i_alu_out[15:0];
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven check of alu_sequencer against a behavioural ALU, plus backpressure and mid-op reset sequences.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        logic [15:0] exp_acc;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] acc, alu_in1, alu_in2;
    logic [3:0]  alu_op;
    logic [31:0] alu_out;
    logic [1:0]  alu_err;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        vecs[16];

    alu_sequencer_if bus();

    alu_sequencer #(.SETTLE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .o_acc     (acc),
        .o_alu_in1 (alu_in1),
        .o_alu_in2 (alu_in2),
        .o_alu_op  (alu_op),
        .i_alu_out (alu_out),
        .i_alu_err (alu_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; its range flag is always set so the sequencer must ignore it,
    // and a divide by zero returns garbage that the sequencer must zero.
    always_comb begin
        alu_out = 32'd0;
        alu_err = 2'b01;
        case (alu_op)
            OP_ADD: alu_out = {16'd0, alu_in1} + {16'd0, alu_in2};
            OP_SUB: alu_out = {16'd0, alu_in1} - {16'd0, alu_in2};
            OP_MUL: alu_out = {16'd0, alu_in1} * {16'd0, alu_in2};
            OP_DIV: begin
                alu_out = (alu_in2 == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_in1 / alu_in2};
                alu_err[1] = (alu_in2 == 16'd0);
            end
            OP_MOD: begin
                alu_out = (alu_in2 == 16'd0) ? 32'hFFFF_FFFF : {16'd0, alu_in1 % alu_in2};
                alu_err[1] = (alu_in2 == 16'd0);
            end
            default: alu_out = 32'd0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one command with rsp_ready=1; lat counts edges after the accept edge until rsp_valid.
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] d, output int lat,
                          output logic [31:0] rd, output logic [1:0] re, output logic [15:0] ra);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = bus.rsp_data;
        re = bus.rsp_err;
        ra = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  bus.rsp_data, 32'd0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
        check({tag, "_acc"},       32'(acc), 32'd0);
        check({tag, "_alu_in"},    {alu_in1, alu_in2}, 32'd0);
        check({tag, "_alu_op"},    32'(alu_op), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [1:0]  re;
        logic [15:0] ra;

        vecs[0]  = '{OP_LOAD, 16'd11,    32'd11,         2'b00, 16'd11,    0};
        vecs[1]  = '{OP_ADD,  16'd51,    32'd62,         2'b00, 16'd62,    2};
        vecs[2]  = '{OP_DIV,  16'd0,     32'd0,          2'b10, 16'd62,    2};
        vecs[3]  = '{4'b1010, 16'd0,     32'd0,          2'b11, 16'd62,    0};
        vecs[4]  = '{OP_NOP,  16'd0,     32'd62,         2'b00, 16'd62,    0};
        vecs[5]  = '{OP_LOAD, 16'd11,    32'd11,         2'b00, 16'd11,    0};
        vecs[6]  = '{OP_SUB,  16'd51,    32'hFFFF_FFD8,  2'b01, 16'hFFD8,  2};
        vecs[7]  = '{OP_LOAD, 16'd63271, 32'd63271,      2'b00, 16'd63271, 0};
        vecs[8]  = '{OP_MUL,  16'd46348, 32'd2932484308, 2'b01, 16'd10452, 2};
        vecs[9]  = '{OP_LOAD, 16'd100,   32'd100,        2'b00, 16'd100,   0};
        vecs[10] = '{OP_DIV,  16'd7,     32'd14,         2'b00, 16'd14,    2};
        vecs[11] = '{OP_LOAD, 16'd100,   32'd100,        2'b00, 16'd100,   0};
        vecs[12] = '{OP_MOD,  16'd7,     32'd2,          2'b00, 16'd2,     2};
        vecs[13] = '{OP_CLR,  16'd9,     32'd0,          2'b00, 16'd0,     0};
        vecs[14] = '{OP_LOAD, 16'd5,     32'd5,          2'b00, 16'd5,     0};
        vecs[15] = '{OP_ADD,  16'hFFFF,  32'h0001_0004,  2'b01, 16'd4,     2};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_data  = 16'd0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, lat, rd, re, ra);
            check($sformatf("v%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("v%0d_err", i),  32'(re), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_acc", i),  32'(ra), 32'(vecs[i].exp_acc));
            check($sformatf("v%0d_back_idle", i), {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
            if (i == 1) check("add_alu_drive", {alu_in1, alu_in2}, {16'd11, 16'd51});
            if (i == 1) check("add_alu_op", 32'(alu_op), 32'(OP_ADD));
            if (i == 4) check("alu_hold_after_local", {12'd0, alu_op, alu_in2}, {12'd0, OP_DIV, 16'd0});
        end

        // Backpressure: ACC=1000, MUL 1000 -> 1000000, range error, ACC=0x4240.
        do_cmd(OP_LOAD, 16'd1000, lat, rd, re, ra);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MUL;
        bus.cmd_data  = 16'd1000;
        @(posedge clk);
        #1;
        check("bp_ready_in_wait", 32'(bus.cmd_ready), 32'd0);
        bus.cmd_op   = OP_CLR;
        bus.cmd_data = 16'd0;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd2);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp%0d_valid_ready", c), {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd2);
            check($sformatf("bp%0d_data", c), bus.rsp_data, 32'd1000000);
            check($sformatf("bp%0d_err", c), 32'(bus.rsp_err), 32'd1);
            check($sformatf("bp%0d_acc", c), 32'(acc), 32'h4240);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_release", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        check("bp_acc_after", 32'(acc), 32'h4240);

        // Reset asserted while an ADD is waiting for the ALU.
        do_cmd(OP_LOAD, 16'd50, lat, rd, re, ra);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_ADD;
        bus.cmd_data  = 16'd5;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check("rst_in_wait", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("midrst_norsp%0d", c), {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'd1);
        end
        do_cmd(OP_NOP, 16'd0, lat, rd, re, ra);
        check("post_rst_nop", rd, 32'd0);
        do_cmd(OP_LOAD, 16'd9, lat, rd, re, ra);
        check("post_rst_load", {rd[15:0], ra}, {16'd9, 16'd9});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
